// File: rtl/div_32_bits_pkg.sv
// Shared multdiv constants and control state encoding.
// Used by the divider top and its iteration step.
package div_32_bits_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = DIV_WIDTH;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

endpackage

// File: rtl/div_32_bits_step.sv
// One non-restoring division step.
// Ports:
//   rem_i   - current partial remainder (signed)
//   q_msb_i - quotient bit shifted into the remainder
//   div_i   - divisor magnitude
//   rem_o   - next partial remainder
//   q_bit_o - new quotient LSB
module div_32_bits_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             q_msb_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shl;
  logic [WIDTH:0] dv;

  assign shl = {rem_i[WIDTH-1:0], q_msb_i};
  assign dv  = {1'b0, div_i};

  // Sign of the remainder before the shift picks add or subtract.
  assign rem_o   = rem_i[WIDTH] ? (shl + dv) : (shl - dv);
  assign q_bit_o = ~rem_o[WIDTH];

endmodule

// File: rtl/div_32_bits.sv
// Sequential signed divider, one non-restoring step per clock.
// Ports:
//   clock, reset_n       - clock, async active-low reset
//   ctrl_DIV             - start pulse, samples both operands
//   data_operandA/B      - dividend / divisor
//   data_result          - quotient, truncated toward zero
//   data_remainder       - remainder, sign of dividend
//   data_exception       - divide by zero
//   data_resultRDY       - one-cycle completion strobe
//   busy                 - operation in flight
module div_32_bits
  import div_32_bits_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] absb_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH:0]   rem_q;
  logic             sa_q;
  logic             sb_q;
  logic             dz_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] remo_q;
  logic             exc_q;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  // 0x80000000 maps to itself, read as an unsigned magnitude.
  assign abs_a = a_q[WIDTH-1] ? (~a_q + 1'b1) : a_q;
  assign abs_b = b_q[WIDTH-1] ? (~b_q + 1'b1) : b_q;

  div_32_bits_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i   (rem_q),
    .q_msb_i (quo_q[WIDTH-1]),
    .div_i   (absb_q),
    .rem_o   (step_rem),
    .q_bit_o (step_q)
  );

  // Final restore; the true remainder fits in the low WIDTH bits.
  assign r_fix = rem_q[WIDTH-1:0]
               + (rem_q[WIDTH] ? absb_q : '0);
  assign q_fin = (sa_q ^ sb_q) ? (~quo_q + 1'b1) : quo_q;
  assign r_fin = sa_q ? (~r_fix + 1'b1) : r_fix;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (ctrl_DIV) state_d = LOAD;
      LOAD: begin
        if (ctrl_DIV)        state_d = LOAD;
        else if (b_q == '0)  state_d = FIX;
        else                 state_d = ITER;
      end
      ITER: begin
        if (ctrl_DIV)           state_d = LOAD;
        else if (cnt_q == LAST) state_d = FIX;
      end
      FIX: state_d = ctrl_DIV ? LOAD : DONE;
      DONE: state_d = ctrl_DIV ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      absb_q <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      dz_q   <= 1'b0;
      res_q  <= '0;
      remo_q <= '0;
      exc_q  <= 1'b0;
    end else if (ctrl_DIV) begin
      // A start in any state restarts; an aborted op never reaches FIX.
      a_q   <= data_operandA;
      b_q   <= data_operandB;
      cnt_q <= '0;
      exc_q <= 1'b0;
    end else begin
      unique case (state_q)
        LOAD: begin
          sa_q   <= a_q[WIDTH-1];
          sb_q   <= b_q[WIDTH-1];
          quo_q  <= abs_a;
          absb_q <= abs_b;
          rem_q  <= '0;
          dz_q   <= (b_q == '0);
          cnt_q  <= '0;
        end
        ITER: begin
          rem_q <= step_rem;
          quo_q <= {quo_q[WIDTH-2:0], step_q};
          cnt_q <= cnt_q + 1'b1;
        end
        FIX: begin
          res_q  <= dz_q ? '0 : q_fin;
          remo_q <= dz_q ? a_q : r_fin;
          exc_q  <= dz_q;
        end
        default: ;
      endcase
    end
  end

  assign data_result    = res_q;
  assign data_remainder = remo_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == DONE);
  assign busy = (state_q == LOAD) || (state_q == ITER)
             || (state_q == FIX);

endmodule

// File: tb/tb_div_32_bits.sv
// Directed self-checking bench for div_32_bits.
// Hand-computed vectors, latency, abort and reset cases.
module tb_div_32_bits;

  logic        clock;
  logic        reset_n;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic [31:0] data_remainder;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int rdy_cnt = 0;

  div_32_bits dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (data_resultRDY) rdy_cnt++;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_DIV = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    data_operandA = 32'hDEAD_BEEF;
    data_operandB = 32'h0000_0001;
  endtask

  task automatic wait_rdy(output int lat);
    lat = 0;
    while (!data_resultRDY && lat < 200) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic run(input string tag,
                     input logic [31:0] a, input logic [31:0] b,
                     input int exp_lat,
                     input logic [31:0] eq, input logic [31:0] er,
                     input logic ee);
    int lat;
    start(a, b);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_exc_clr"}, 32'(data_exception), 32'd0);
    wait_rdy(lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_q"}, data_result, eq);
    check({tag, "_r"}, data_remainder, er);
    check({tag, "_exc"}, 32'(data_exception), 32'(ee));
    check({tag, "_busy_rdy"}, 32'(busy), 32'd0);
    @(negedge clock);
    check({tag, "_rdy_1cyc"}, 32'(data_resultRDY), 32'd0);
    check({tag, "_q_hold"}, data_result, eq);
  endtask

  initial begin
    int lat;
    int r0;
    reset_n = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = 32'h0;
    data_operandB = 32'h0;
    #12;
    check("rst_q", data_result, 32'h0);
    check("rst_r", data_remainder, 32'h0);
    check("rst_exc", 32'(data_exception), 32'd0);
    check("rst_rdy", 32'(data_resultRDY), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    run("p100_7", 32'd100, 32'd7, 34, 32'd14, 32'd2, 1'b0);
    run("m100_7", 32'hFFFF_FF9C, 32'd7, 34,
        32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    run("p100_m7", 32'd100, 32'hFFFF_FFF9, 34,
        32'hFFFF_FFF2, 32'd2, 1'b0);
    run("div0", 32'd5, 32'd0, 2, 32'd0, 32'd5, 1'b1);
    run("p9_3", 32'd9, 32'd3, 34, 32'd3, 32'd0, 1'b0);
    run("minint", 32'h8000_0000, 32'hFFFF_FFFF, 34,
        32'h8000_0000, 32'd0, 1'b0);
    run("p3_10", 32'd3, 32'd10, 34, 32'd0, 32'd3, 1'b0);

    // Abort mid-iteration with a fresh operation.
    r0 = rdy_cnt;
    start(32'd1000, 32'd10);
    repeat (11) @(negedge clock);
    check("abort_no_rdy", 32'(rdy_cnt - r0), 32'd0);
    start(32'd81, 32'd9);
    wait_rdy(lat);
    check("abort_lat", 32'(lat), 32'd34);
    check("abort_q", data_result, 32'd9);
    check("abort_r", data_remainder, 32'd0);
    @(negedge clock);
    check("abort_one_rdy", 32'(rdy_cnt - r0), 32'd1);

    // Asynchronous reset during iteration.
    start(32'd1000, 32'd10);
    repeat (12) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("arst_q", data_result, 32'h0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_rdy", 32'(data_resultRDY), 32'd0);
    r0 = rdy_cnt;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    check("arst_no_rdy", 32'(rdy_cnt - r0), 32'd0);
    check("arst_idle", 32'(busy), 32'd0);
    run("p50_5", 32'd50, 32'd5, 34, 32'd10, 32'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
